// File: rtl/ysyx_220066_ex_iter_pkg.sv
// rtl/ysyx_220066_ex_iter_pkg.sv - shared types and encodings for the iterative execute stage
package ysyx_220066_ex_iter_pkg;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [1:0] BSEL_SRC2 = 2'b00;
    localparam logic [1:0] BSEL_FOUR = 2'b01;

    localparam int MDU_BIT = 5;
    localparam int ALT_BIT = 4;
    localparam int W_BIT   = 3;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_JAL  = 3'd1;
    localparam logic [2:0] BR_JALR = 3'd2;
    localparam logic [2:0] BR_BEQ  = 3'd3;
    localparam logic [2:0] BR_BNE  = 3'd4;
    localparam logic [2:0] BR_BLT  = 3'd5;
    localparam logic [2:0] BR_BGE  = 3'd6;
    localparam logic [2:0] BR_BLTU = 3'd7;

endpackage

// File: rtl/ysyx_220066_ex_iter_if.sv
// rtl/ysyx_220066_ex_iter_if.sv - ID-side and MEM-side handshake bundle of the execute stage
interface ysyx_220066_ex_iter_if #(parameter int XLEN = 64);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] in_pc;
    logic            alu_a_sel;
    logic [1:0]      alu_b_sel;
    logic [5:0]      alu_ctr;
    logic [2:0]      branch;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] nxtpc;

    modport master (
        output in_valid, src1, src2, imm, in_pc, alu_a_sel, alu_b_sel, alu_ctr, branch, flush, out_ready,
        input  in_ready, out_valid, result, nxtpc
    );
    modport slave (
        input  in_valid, src1, src2, imm, in_pc, alu_a_sel, alu_b_sel, alu_ctr, branch, flush, out_ready,
        output in_ready, out_valid, result, nxtpc
    );
endinterface

// File: rtl/ysyx_220066_mdu_iter.sv
// rtl/ysyx_220066_mdu_iter.sv - radix-2 iterative RV64M multiply/divide core
module ysyx_220066_mdu_iter
    import ysyx_220066_ex_iter_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int WORD_ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic            word_in,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            early,
    output logic [XLEN-1:0] early_res,
    output logic            done,
    output logic [XLEN-1:0] res
);
    localparam int CW         = $clog2(XLEN + 1);
    localparam int WORD_SHIFT = XLEN - 32;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic              word, is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0]   xa, xb, mag_a, mag_b, early_raw;
    logic              busy, word_q, neg_q, rneg_q, ge;
    logic [2:0]        op_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_nx, prod;
    logic [XLEN-1:0]   mq, md, mq_nx, rem_nx, quo, rmd, raw;
    logic [XLEN:0]     rem_sh;

    // Operand conditioning: W ops use the low word, extended per signedness.
    always_comb begin
        word   = word_in & (XLEN == 64);
        is_div = op[2];
        a_sgn  = is_div ? ~op[0] : (op == F3_MULH || op == F3_MULHSU);
        b_sgn  = is_div ? ~op[0] : (op == F3_MULH);
        xa     = word ? (a_sgn ? sext32(a[31:0]) : XLEN'(a[31:0])) : a;
        xb     = word ? (b_sgn ? sext32(b[31:0]) : XLEN'(b[31:0])) : b;
        a_neg  = a_sgn & xa[XLEN-1];
        b_neg  = b_sgn & xb[XLEN-1];
        mag_a  = a_neg ? -xa : xa;
        mag_b  = b_neg ? -xb : xb;
        div_zero  = is_div & (xb == '0);
        ovf       = is_div & ~op[0] & (xa == (word ? sext32(32'h8000_0000) : MIN_NEG)) & (&xb);
        early     = div_zero | ovf;
        if (op[1]) early_raw = div_zero ? xa : '0;
        else       early_raw = div_zero ? '1 : xa;
        early_res = word ? sext32(early_raw[31:0]) : early_raw;
    end

    // One MSB-first step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        rem_sh = {acc[XLEN-1:0], mq[XLEN-1]};
        ge     = rem_sh >= {1'b0, md};
        rem_nx = ge ? rem_sh[XLEN-1:0] - md : rem_sh[XLEN-1:0];
        acc_nx = op_q[2] ? {{XLEN{1'b0}}, rem_nx}
                         : (acc << 1) + (mq[XLEN-1] ? {{XLEN{1'b0}}, md} : '0);
        mq_nx  = {mq[XLEN-2:0], op_q[2] & ge};
        prod   = neg_q ? -acc_nx : acc_nx;
        quo    = neg_q ? -mq_nx : mq_nx;
        rmd    = rneg_q ? -rem_nx : rem_nx;
        case (op_q)
            F3_MUL:                       raw = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: raw = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              raw = quo;
            default:                      raw = rmd;
        endcase
        res  = word_q ? sext32(raw[31:0]) : raw;
        done = busy & (cnt == (word_q ? CW'(WORD_ITER - 1) : CW'(XLEN - 1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            op_q   <= '0;
            word_q <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            acc    <= '0;
            mq     <= '0;
            md     <= '0;
        end else if (kill) begin
            busy <= 1'b0;
        end else if (start && !early) begin
            busy   <= 1'b1;
            cnt    <= '0;
            op_q   <= op;
            word_q <= word;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            acc    <= '0;
            md     <= is_div ? mag_b : mag_a;
            mq     <= word ? ((is_div ? mag_a : mag_b) << WORD_SHIFT) : (is_div ? mag_a : mag_b);
        end else if (busy) begin
            acc <= acc_nx;
            mq  <= mq_nx;
            cnt <= cnt + CW'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_220066_ex_iter.sv
// rtl/ysyx_220066_ex_iter.sv - multi-cycle execute stage: ALU, next-PC and iterative MDU
module ysyx_220066_ex_iter
    import ysyx_220066_ex_iter_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int WORD_ITER = 32
) (
    input logic clk,
    input logic rst,
    ysyx_220066_ex_iter_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    state_t          state, state_n;
    logic [XLEN-1:0] result_q, nxtpc_q, alu_a, alu_b, alu_w, alu_raw, alu_res;
    logic [XLEN-1:0] npc, seq_pc, br_tgt, mdu_early_res, mdu_res;
    logic [SHW-1:0]  sh;
    logic            is_mdu, word, alt, accept, go_busy, mdu_early, mdu_done;

    assign is_mdu = bus.alu_ctr[MDU_BIT];
    assign alt    = bus.alu_ctr[ALT_BIT];
    assign word   = bus.alu_ctr[W_BIT] & (XLEN == 64);

    always_comb begin
        alu_a = bus.alu_a_sel ? bus.in_pc : bus.src1;
        if (bus.alu_b_sel[1])                alu_b = bus.imm;
        else if (bus.alu_b_sel == BSEL_FOUR) alu_b = XLEN'(4);
        else                                 alu_b = bus.src2;
        sh    = word ? SHW'(alu_b[4:0]) : alu_b[SHW-1:0];
        // Right shifts of W ops must see a properly extended 32-bit source.
        alu_w = word ? (alt ? sext32(alu_a[31:0]) : XLEN'(alu_a[31:0])) : alu_a;
        case (bus.alu_ctr[2:0])
            3'd0:    alu_raw = alt ? alu_a - alu_b : alu_a + alu_b;
            3'd1:    alu_raw = alu_a << sh;
            3'd2:    alu_raw = XLEN'($signed(alu_a) < $signed(alu_b));
            3'd3:    alu_raw = XLEN'(alu_a < alu_b);
            3'd4:    alu_raw = alu_a ^ alu_b;
            3'd5:    alu_raw = alt ? XLEN'($signed(alu_w) >>> sh) : alu_w >> sh;
            3'd6:    alu_raw = alu_a | alu_b;
            default: alu_raw = alu_a & alu_b;
        endcase
        alu_res = word ? sext32(alu_raw[31:0]) : alu_raw;
    end

    always_comb begin
        seq_pc = bus.in_pc + XLEN'(4);
        br_tgt = bus.in_pc + bus.imm;
        case (bus.branch)
            BR_JAL:  npc = br_tgt;
            BR_JALR: npc = (bus.src1 + bus.imm) & ~XLEN'(1);
            BR_BEQ:  npc = (bus.src1 == bus.src2) ? br_tgt : seq_pc;
            BR_BNE:  npc = (bus.src1 != bus.src2) ? br_tgt : seq_pc;
            BR_BLT:  npc = ($signed(bus.src1) <  $signed(bus.src2)) ? br_tgt : seq_pc;
            BR_BGE:  npc = ($signed(bus.src1) >= $signed(bus.src2)) ? br_tgt : seq_pc;
            BR_BLTU: npc = (bus.src1 < bus.src2) ? br_tgt : seq_pc;
            default: npc = seq_pc;
        endcase
    end

    ysyx_220066_mdu_iter #(.XLEN(XLEN), .WORD_ITER(WORD_ITER)) u_mdu (
        .clk       (clk),
        .rst       (rst),
        .start     (accept & is_mdu),
        .kill      (bus.flush),
        .op        (bus.alu_ctr[2:0]),
        .word_in   (bus.alu_ctr[W_BIT]),
        .a         (bus.src1),
        .b         (bus.src2),
        .early     (mdu_early),
        .early_res (mdu_early_res),
        .done      (mdu_done),
        .res       (mdu_res)
    );

    assign bus.in_ready  = (state == S_IDLE) | ((state == S_DONE) & bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready & ~bus.flush;
    assign go_busy       = is_mdu & ~mdu_early;
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = result_q;
    assign bus.nxtpc     = nxtpc_q;

    always_comb begin
        state_n = state;
        if (bus.flush) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept) state_n = go_busy ? S_BUSY : S_DONE;
                S_BUSY:  if (mdu_done) state_n = S_DONE;
                S_DONE:  if (bus.out_ready) state_n = accept ? (go_busy ? S_BUSY : S_DONE) : S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            nxtpc_q  <= '0;
        end else if (accept) begin
            nxtpc_q <= is_mdu ? seq_pc : npc;
            if (!is_mdu)        result_q <= alu_res;
            else if (mdu_early) result_q <= mdu_early_res;
        end else if (state == S_BUSY && mdu_done && !bus.flush) begin
            result_q <= mdu_res;
        end
    end

endmodule
